// File: rtl/store_queue_pkg.sv
// Shared defaults and entry layout for the store queue.
package store_queue_pkg;
  localparam int SQ_DEPTH    = 16;
  localparam int SQ_ADDR_LEN = 32;
  localparam int SQ_DATA_LEN = 32;
  localparam int SQ_BYTE_OFS = $clog2(SQ_DATA_LEN/8);

  typedef struct packed {
    logic [SQ_ADDR_LEN-1:0]   addr;
    logic [SQ_DATA_LEN-1:0]   data;
    logic [SQ_DATA_LEN/8-1:0] mask;
  } sq_entry_t;

  function automatic int byte_ofs(input int data_len);
    return $clog2(data_len/8);
  endfunction
endpackage

// File: rtl/store_queue_fwd_match.sv
// Wrap-aware youngest-first forwarding matcher.
// STORE_QUEUE_BYTE_MERGE_EN: each byte lane picks its own youngest masked match.
module store_queue_fwd_match
  import store_queue_pkg::*;
#(
  parameter  int DEPTH    = SQ_DEPTH,
  parameter  int WA       = SQ_ADDR_LEN - SQ_BYTE_OFS,
  parameter  int NB       = SQ_DATA_LEN/8,
  localparam int PTR_BITS = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]                ent_vld,
  input  logic [DEPTH-1:0][WA-1:0]        ent_addr,
  input  logic [DEPTH-1:0][NB-1:0]        ent_mask,
  input  logic [WA-1:0]                   load_addr,
  input  logic [PTR_BITS:0]               head,
  input  logic [PTR_BITS:0]               tail,
  output logic                            hit,
  output logic [NB-1:0]                   lane_sel,
  output logic [NB-1:0][PTR_BITS-1:0]     lane_idx
);
  logic [PTR_BITS:0]                cnt;
  logic [DEPTH-1:0]                 match;
  logic [DEPTH-1:0][PTR_BITS-1:0]   ord;

  assign cnt = tail - head;

  // ord[k] is the slot of the k-th youngest entry
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ord[k]   = tail[PTR_BITS-1:0] - PTR_BITS'(k + 1);
      match[k] = ent_vld[k] && (ent_addr[k] == load_addr);
    end
  end

`ifdef STORE_QUEUE_BYTE_MERGE_EN
  for (genvar b = 0; b < NB; b++) begin : g_lane
    logic                sel;
    logic [PTR_BITS-1:0] idx;
    always_comb begin
      sel = 1'b0;
      idx = '0;
      for (int k = DEPTH-1; k >= 0; k--)
        if ((PTR_BITS+1)'(k) < cnt && match[ord[k]] && ent_mask[ord[k]][b]) begin
          sel = 1'b1;
          idx = ord[k];
        end
    end
    assign lane_sel[b] = sel;
    assign lane_idx[b] = idx;
  end
  assign hit = |lane_sel;
`else
  logic [PTR_BITS-1:0] widx;
  always_comb begin
    hit  = 1'b0;
    widx = '0;
    for (int k = DEPTH-1; k >= 0; k--)
      if ((PTR_BITS+1)'(k) < cnt && match[ord[k]]) begin
        hit  = 1'b1;
        widx = ord[k];
      end
  end
  for (genvar b = 0; b < NB; b++) begin : g_lane
    assign lane_sel[b] = hit && ent_mask[widx][b];
    assign lane_idx[b] = widx;
  end
`endif
endmodule

// File: rtl/store_queue.sv
// Circular store queue: holds speculative stores, drains committed ones, forwards to loads.
// STORE_QUEUE_BYTE_MERGE_EN selects per-byte merge forwarding.
module store_queue
  import store_queue_pkg::*;
#(
  parameter  int DEPTH    = SQ_DEPTH,
  parameter  int ADDR_LEN = SQ_ADDR_LEN,
  parameter  int DATA_LEN = SQ_DATA_LEN,
  localparam int PTR_BITS = $clog2(DEPTH),
  localparam int NB       = DATA_LEN/8
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                alloc_valid_i,
  input  logic [ADDR_LEN-1:0] alloc_addr_i,
  input  logic [DATA_LEN-1:0] alloc_data_i,
  input  logic [NB-1:0]       alloc_mask_i,
  output logic                alloc_ready_o,
  input  logic                commit_i,
  input  logic                flush_i,
  input  logic                load_valid_i,
  input  logic [ADDR_LEN-1:0] load_addr_i,
  output logic                load_hit_o,
  output logic [DATA_LEN-1:0] load_data_o,
  output logic [NB-1:0]       load_mask_o,
  output logic                mem_req_o,
  output logic [ADDR_LEN-1:0] mem_addr_o,
  output logic [DATA_LEN-1:0] mem_data_o,
  output logic [NB-1:0]       mem_mask_o,
  input  logic                mem_ack_i,
  output logic                full_o,
  output logic                empty_o,
  output logic [PTR_BITS:0]   count_o
);
  localparam int OFS = byte_ofs(DATA_LEN);
  localparam int WA  = ADDR_LEN - OFS;

  logic [PTR_BITS:0]                head_q, cmt_q, tail_q, cmt_n, tail_n;
  logic [PTR_BITS-1:0]              hidx, tidx, off;
  logic [DEPTH-1:0]                 vld_q, set_v, clr_v;
  logic [DEPTH-1:0][ADDR_LEN-1:0]   addr_q;
  logic [DEPTH-1:0][NB-1:0][7:0]    data_q;
  logic [DEPTH-1:0][NB-1:0]         mask_q;
  logic [DEPTH-1:0][WA-1:0]         waddr;
  logic                             do_alloc, do_commit, do_ack;
  logic                             fwd_hit;
  logic [NB-1:0]                    lane_sel;
  logic [NB-1:0][PTR_BITS-1:0]      lane_idx;
  logic [NB-1:0][7:0]               fwd_data;
  logic                             unused_lo;

  assign hidx          = head_q[PTR_BITS-1:0];
  assign tidx          = tail_q[PTR_BITS-1:0];
  assign count_o       = tail_q - head_q;
  assign full_o        = count_o == (PTR_BITS+1)'(DEPTH);
  assign empty_o       = tail_q == head_q;
  assign alloc_ready_o = !full_o;
  assign mem_req_o     = head_q != cmt_q;
  assign mem_addr_o    = addr_q[hidx];
  assign mem_data_o    = data_q[hidx];
  assign mem_mask_o    = mask_q[hidx];
  assign unused_lo     = ^load_addr_i[OFS-1:0];

  // full is judged on registered state; flush wins over a same-cycle alloc
  assign do_alloc  = alloc_valid_i && !full_o && !flush_i;
  assign do_commit = commit_i && (cmt_q != tail_q);
  assign do_ack    = mem_req_o && mem_ack_i;
  assign cmt_n     = cmt_q + (PTR_BITS+1)'(do_commit);
  assign tail_n    = flush_i ? cmt_n : tail_q + (PTR_BITS+1)'(do_alloc);

  always_comb begin
    set_v = '0;
    clr_v = '0;
    off   = '0;
    if (do_alloc) set_v[tidx] = 1'b1;
    if (do_ack)   clr_v[hidx] = 1'b1;
    if (flush_i)
      for (int i = 0; i < DEPTH; i++) begin
        off = PTR_BITS'(i) - cmt_n[PTR_BITS-1:0];
        if ({1'b0, off} < (tail_q - cmt_n)) clr_v[i] = 1'b1;
      end
    for (int i = 0; i < DEPTH; i++) waddr[i] = addr_q[i][ADDR_LEN-1:OFS];
  end

  store_queue_fwd_match #(.DEPTH(DEPTH), .WA(WA), .NB(NB)) u_match (
    .ent_vld   (vld_q),
    .ent_addr  (waddr),
    .ent_mask  (mask_q),
    .load_addr (load_addr_i[ADDR_LEN-1:OFS]),
    .head      (head_q),
    .tail      (tail_q),
    .hit       (fwd_hit),
    .lane_sel  (lane_sel),
    .lane_idx  (lane_idx)
  );

  always_comb begin
    for (int b = 0; b < NB; b++)
`ifdef STORE_QUEUE_BYTE_MERGE_EN
      fwd_data[b] = lane_sel[b] ? data_q[lane_idx[b]][b] : 8'h00;
`else
      fwd_data[b] = fwd_hit ? data_q[lane_idx[b]][b] : 8'h00;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q      <= '0;
      cmt_q       <= '0;
      tail_q      <= '0;
      vld_q       <= '0;
      load_hit_o  <= 1'b0;
      load_data_o <= '0;
      load_mask_o <= '0;
    end else begin
      head_q      <= head_q + (PTR_BITS+1)'(do_ack);
      cmt_q       <= cmt_n;
      tail_q      <= tail_n;
      vld_q       <= (vld_q & ~clr_v) | set_v;
      load_hit_o  <= load_valid_i && fwd_hit;
      load_data_o <= load_valid_i ? fwd_data : '0;
      load_mask_o <= load_valid_i ? lane_sel : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_alloc) begin
      addr_q[tidx] <= alloc_addr_i;
      data_q[tidx] <= alloc_data_i;
      mask_q[tidx] <= alloc_mask_i;
    end
  end

  a_commit_has_entry: assert property (@(posedge clk_i) disable iff (reset_i)
    commit_i |-> (cmt_q != tail_q));
endmodule

// File: tb/tb_store_queue.sv
// Store queue bench: directed table, corner sequences and random traffic vs a queue model.
module tb_store_queue;
  import store_queue_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        alloc_valid_i, alloc_ready_o, commit_i, flush_i, load_valid_i;
  logic [31:0] alloc_addr_i, alloc_data_i, load_addr_i;
  logic [3:0]  alloc_mask_i, load_mask_o, mem_mask_o;
  logic        load_hit_o, mem_req_o, mem_ack_i, full_o, empty_o;
  logic [31:0] load_data_o, mem_addr_o, mem_data_o;
  logic [4:0]  count_o;

  store_queue dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .alloc_valid_i(alloc_valid_i), .alloc_addr_i(alloc_addr_i), .alloc_data_i(alloc_data_i),
    .alloc_mask_i(alloc_mask_i), .alloc_ready_o(alloc_ready_o),
    .commit_i(commit_i), .flush_i(flush_i),
    .load_valid_i(load_valid_i), .load_addr_i(load_addr_i),
    .load_hit_o(load_hit_o), .load_data_o(load_data_o), .load_mask_o(load_mask_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_mask_o(mem_mask_o), .mem_ack_i(mem_ack_i),
    .full_o(full_o), .empty_o(empty_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic av; logic [31:0] aa, ad; logic [3:0] am;
    logic cm, fl, lv; logic [31:0] la; logic ack;
  } in_t;

  typedef struct {
    in_t i;
    int e_cnt; logic e_req, e_hit; logic [31:0] e_ldata; logic [3:0] e_lmask;
  } vec_t;

  int n_chk = 0, n_fail = 0;

  // model: program-ordered list of live stores, the first ncmt of them committed
  sq_entry_t q[$];
  int        ncmt = 0;
  logic        lh_e;
  logic [31:0] ld_e;
  logic [3:0]  lm_e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic in_t mk(input logic av, input logic [31:0] aa, input logic [31:0] ad,
                             input logic [3:0] am, input logic cm, input logic fl,
                             input logic lv, input logic [31:0] la, input logic ack);
    in_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.am = am; v.cm = cm; v.fl = fl;
    v.lv = lv; v.la = la; v.ack = ack;
    return v;
  endfunction

  function automatic in_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic model_lookup(input logic lv, input logic [31:0] la,
                              output logic h, output logic [31:0] d, output logic [3:0] m);
    h = 0; d = 0; m = 0;
    if (lv) begin
`ifdef STORE_QUEUE_BYTE_MERGE_EN
      for (int b = 0; b < 4; b++)
        for (int k = q.size()-1; k >= 0; k--)
          if (q[k].addr[31:2] == la[31:2] && q[k].mask[b]) begin
            d[b*8 +: 8] = q[k].data[b*8 +: 8];
            m[b] = 1'b1;
            break;
          end
      h = |m;
`else
      for (int k = q.size()-1; k >= 0; k--)
        if (q[k].addr[31:2] == la[31:2]) begin
          h = 1; d = q[k].data; m = q[k].mask;
          break;
        end
`endif
    end
  endtask

  task automatic model_update(input in_t v);
    int sz = q.size();
    bit c = v.cm && (sz - ncmt > 0);
    bit a = v.ack && (ncmt > 0);
    sq_entry_t e;
    if (a) begin void'(q.pop_front()); ncmt--; end
    if (c) ncmt++;
    if (v.fl) begin
      while (q.size() > ncmt) void'(q.pop_back());
    end else if (v.av && sz < SQ_DEPTH) begin
      e.addr = v.aa; e.data = v.ad; e.mask = v.am;
      q.push_back(e);
    end
  endtask

  task automatic check_model();
    chk("count", count_o, q.size());
    chk("full", full_o, q.size() == SQ_DEPTH);
    chk("empty", empty_o, q.size() == 0);
    chk("alloc_ready", alloc_ready_o, q.size() != SQ_DEPTH);
    chk("mem_req", mem_req_o, ncmt > 0);
    if (ncmt > 0) begin
      chk("mem_addr", mem_addr_o, q[0].addr);
      chk("mem_data", mem_data_o, q[0].data);
      chk("mem_mask", mem_mask_o, q[0].mask);
    end
    chk("load_hit", load_hit_o, lh_e);
    chk("load_mask", load_mask_o, lm_e);
    if (lh_e) chk("load_data", load_data_o, ld_e);
  endtask

  task automatic step(input in_t v);
    logic h; logic [31:0] d; logic [3:0] m;
    alloc_valid_i = v.av; alloc_addr_i = v.aa; alloc_data_i = v.ad; alloc_mask_i = v.am;
    commit_i = v.cm; flush_i = v.fl; load_valid_i = v.lv; load_addr_i = v.la; mem_ack_i = v.ack;
    model_lookup(v.lv, v.la, h, d, m);
    @(posedge clk_i);
    model_update(v);
    lh_e = h; ld_e = d; lm_e = m;
    #1;
    check_model();
  endtask

  task automatic drain_all();
    for (int c = 0; c < 100 && q.size() > 0; c++)
      step(mk(0, 0, 0, 0, (q.size() - ncmt) > 0, 0, 0, 0, 1));
  endtask

  vec_t tbl[19];
  logic [31:0] seen[8];
  int nw;
  in_t v;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    reset_i = 1; alloc_valid_i = 0; alloc_addr_i = 0; alloc_data_i = 0; alloc_mask_i = 0;
    commit_i = 0; flush_i = 0; load_valid_i = 0; load_addr_i = 0; mem_ack_i = 0;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 0;
    chk("rst_load_hit", load_hit_o, 0);
    chk("rst_load_data", load_data_o, 0);
    chk("rst_load_mask", load_mask_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_full", full_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_count", count_o, 0);
    chk("rst_ready", alloc_ready_o, 1);
    lh_e = 0; ld_e = 0; lm_e = 0;

    // directed table: forwarding, drain-while-lookup, flush
    tbl[0]  = '{mk(1, 32'h200, 32'hAAAA_AAAA, 4'hF, 0, 0, 0, 0, 0),     1, 0, 0, 0, 0};
    tbl[1]  = '{mk(1, 32'h200, 32'h1111_2222, 4'hF, 0, 0, 0, 0, 0),     2, 0, 0, 0, 0};
    tbl[2]  = '{mk(0, 0, 0, 0, 0, 0, 1, 32'h200, 0),                    2, 0, 1, 32'h1111_2222, 4'hF};
    tbl[3]  = '{mk(0, 0, 0, 0, 0, 0, 1, 32'h204, 0),                    2, 0, 0, 0, 0};
    tbl[4]  = '{mk(0, 0, 0, 0, 1, 0, 1, 32'h202, 0),                    2, 1, 1, 32'h1111_2222, 4'hF};
    tbl[5]  = '{mk(0, 0, 0, 0, 1, 0, 0, 0, 0),                          2, 1, 0, 0, 0};
    tbl[6]  = '{mk(0, 0, 0, 0, 0, 0, 1, 32'h200, 1),                    1, 1, 1, 32'h1111_2222, 4'hF};
    tbl[7]  = '{mk(0, 0, 0, 0, 0, 0, 1, 32'h200, 1),                    0, 0, 1, 32'h1111_2222, 4'hF};
    tbl[8]  = '{mk(0, 0, 0, 0, 0, 0, 1, 32'h200, 0),                    0, 0, 0, 0, 0};
    for (int k = 0; k < 4; k++)
      tbl[9+k] = '{mk(1, 32'h300 + 4*k, k + 1, 4'hF, 0, 0, 0, 0, 0),    k + 1, 0, 0, 0, 0};
    tbl[13] = '{mk(0, 0, 0, 0, 1, 0, 0, 0, 0),                          4, 1, 0, 0, 0};
    tbl[14] = '{mk(0, 0, 0, 0, 1, 0, 0, 0, 0),                          4, 1, 0, 0, 0};
    tbl[15] = '{mk(1, 32'h310, 5, 4'hF, 0, 1, 0, 0, 0),                 2, 1, 0, 0, 0};
    tbl[16] = '{mk(0, 0, 0, 0, 0, 0, 1, 32'h308, 0),                    2, 1, 0, 0, 0};
    tbl[17] = '{mk(0, 0, 0, 0, 0, 0, 1, 32'h304, 1),                    1, 1, 1, 2, 4'hF};
    tbl[18] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1),                          0, 0, 0, 0, 0};
    for (int r = 0; r < 19; r++) begin
      step(tbl[r].i);
      chk($sformatf("tbl%0d_count", r), count_o, tbl[r].e_cnt);
      chk($sformatf("tbl%0d_req", r), mem_req_o, tbl[r].e_req);
      chk($sformatf("tbl%0d_hit", r), load_hit_o, tbl[r].e_hit);
      chk($sformatf("tbl%0d_lmask", r), load_mask_o, tbl[r].e_lmask);
      if (tbl[r].e_hit) chk($sformatf("tbl%0d_ldata", r), load_data_o, tbl[r].e_ldata);
    end

    // fill to full, overflow alloc dropped
    for (int k = 0; k < 16; k++) step(mk(1, 32'h100 + 4*k, k, 4'hF, 0, 0, 0, 0, 0));
    chk("fill_full", full_o, 1);
    chk("fill_count", count_o, 16);
    chk("fill_ready", alloc_ready_o, 0);
    chk("fill_req", mem_req_o, 0);
    step(mk(1, 32'h140, 32'hDEAD, 4'hF, 0, 0, 1, 32'h13C, 0));
    chk("fill_drop_count", count_o, 16);
    chk("fill_fwd_last", load_data_o, 15);
    drain_all();
    chk("fill_drained", empty_o, 1);

    // hold head until acked, then drain exactly the committed ones
    for (int k = 0; k < 5; k++) step(mk(1, 32'h600 + 4*k, 32'h60 + k, 4'hF, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) step(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++) begin
      step(idle());
      chk("hold_req", mem_req_o, 1);
      chk("hold_addr", mem_addr_o, 32'h600);
    end
    nw = 0;
    for (int c = 0; c < 6 && mem_req_o; c++) begin
      seen[nw] = mem_addr_o; nw++;
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    end
    chk("drain_writes", nw, 3);
    for (int k = 0; k < 3; k++) chk("drain_order", seen[k], 32'h600 + 4*k);
    chk("drain_req_done", mem_req_o, 0);
    chk("drain_left", count_o, 2);
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
    chk("drain_flushed", empty_o, 1);

    // partial-mask stores to the same word
    step(mk(1, 32'h400, 32'h0000_BBBB, 4'h3, 0, 0, 0, 0, 0));
    step(mk(1, 32'h400, 32'hCCCC_0000, 4'hC, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 1, 32'h400, 0));
    chk("merge_hit", load_hit_o, 1);
`ifdef STORE_QUEUE_BYTE_MERGE_EN
    chk("merge_data", load_data_o, 32'hCCCC_BBBB);
    chk("merge_mask", load_mask_o, 4'hF);
`else
    chk("merge_data", load_data_o, 32'hCCCC_0000);
    chk("merge_mask", load_mask_o, 4'hC);
`endif
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));

    // wrap: steady alloc/commit/ack stream
    for (int c = 0; c < 40; c++)
      step(mk(1, 32'h700 + 4*(c % 8), c, 4'hF, (q.size() - ncmt) > 0, 0, 1, 32'h700 + 4*(c % 8), 1));
    drain_all();
    chk("wrap_empty", empty_o, 1);

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      v = idle();
      v.av  = $urandom_range(0, 99) < 60;
      v.aa  = 32'h500 + 4*$urandom_range(0, 7);
      v.ad  = $urandom;
      v.am  = 4'($urandom_range(1, 15));
      v.cm  = ((q.size() - ncmt) > 0) && ($urandom_range(0, 99) < 50);
      v.fl  = $urandom_range(0, 99) < 4;
      v.lv  = 1'($urandom_range(0, 1));
      v.la  = 32'h500 + $urandom_range(0, 31);
      v.ack = $urandom_range(0, 99) < 50;
      step(v);
    end
    drain_all();
    chk("rand_empty", empty_o, 1);

    // reset in the middle of draining
    for (int k = 0; k < 3; k++) step(mk(1, 32'h800 + 4*k, k, 4'hF, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) step(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    chk("mid_req", mem_req_o, 1);
    reset_i = 1;
    @(posedge clk_i);
    #1 reset_i = 0;
    q.delete(); ncmt = 0;
    chk("mid_rst_req", mem_req_o, 0);
    chk("mid_rst_count", count_o, 0);
    chk("mid_rst_empty", empty_o, 1);
    lh_e = 0; ld_e = 0; lm_e = 0;
    step(mk(0, 0, 0, 0, 0, 0, 1, 32'h800, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/store_queue.md
Name: store_queue

Overview:
Parametrised circular store queue between the LSU and the data memory port, in the EX stage.
- Holds speculative stores until the ROB commits them, then drains them in program order through a valid/ack memory handshake.
- Forwards the youngest matching store data to loads, with byte masks.
- Provides full/empty backpressure and flushes uncommitted stores on pipeline squash.

Parameters:
DEPTH, 16, number of entries; power of two, minimum 2.
ADDR_LEN, 32, address width.
DATA_LEN, 32, data width; multiple of 8.
PTR_BITS, log2(DEPTH), index width; derived, not overridden.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- alloc_valid_i  in  1  store issued this cycle
- alloc_addr_i  in  ADDR_LEN  store address
- alloc_data_i  in  DATA_LEN  store data
- alloc_mask_i  in  DATA_LEN/8  byte enables
- alloc_ready_o  out  1  queue can accept a store; equals !full_o
- commit_i  in  1  ROB commits the oldest uncommitted store
- flush_i  in  1  squash all uncommitted entries
- load_valid_i  in  1  load lookup request
- load_addr_i  in  ADDR_LEN  load address
- load_hit_o  out  1  forwarding hit, registered
- load_data_o  out  DATA_LEN  forwarded data, registered
- load_mask_o  out  DATA_LEN/8  bytes supplied by forwarding, registered
- mem_req_o  out  1  committed head entry awaiting write
- mem_addr_o  out  ADDR_LEN  head address
- mem_data_o  out  DATA_LEN  head data
- mem_mask_o  out  DATA_LEN/8  head byte enables
- mem_ack_i  in  1  memory accepted head write
- full_o  out  1  count == DEPTH
- empty_o  out  1  count == 0
- count_o  out  PTR_BITS+1  occupied entries

Behaviour:
- Pointers:
  - head (oldest), cmt (first uncommitted) and tail (next free) are each PTR_BITS+1 wide, with the MSB as wrap bit.
  - count = tail-head, ncommitted = cmt-head.
  - All pointers wrap modulo 2*DEPTH. Every entry is usable; no reserved slot.
- Reset: all pointers 0, all entries invalid.
  - Outputs after reset: load_hit_o=0, load_data_o=0, load_mask_o=0, mem_req_o=0, full_o=0, empty_o=1, count_o=0, alloc_ready_o=1.
- Allocate:
  - Occurs when alloc_valid_i && alloc_ready_o. Writes the entry at tail, then tail+1.
  - alloc_valid_i while full is dropped; the issuer must respect alloc_ready_o.
- Commit:
  - Occurs when commit_i && cmt != tail. Sets cmt+1.
  - commit_i with no uncommitted entry is ignored (covered by an assertion).
- Drain:
  - mem_req_o = (head != cmt), combinational from state.
  - mem_addr/data/mask are taken from entry[head] and stay stable until mem_ack_i.
  - On mem_req_o && mem_ack_i, head+1. Back-to-back acks drain one entry per cycle.
  - mem_ack_i without mem_req_o is ignored.
- Flush:
  - Sets tail <- cmt after the same-cycle commit is applied. Committed entries keep draining.
  - In the same cycle, flush_i overrides alloc (alloc dropped).
- Load forwarding:
  - Lookup on load_valid_i compares word address (addr[ADDR_LEN-1:log2(DATA_LEN/8)]) against every valid entry between head and tail, including the entry being acked that cycle.
  - The youngest match (nearest tail, wrap-aware) wins. Its data and mask are registered and appear next cycle.
  - load_hit_o = 1 for that single cycle. With no match or no request: load_hit_o=0 and load_mask_o=0.
  - Lookup does not block allocate, commit or drain; all may occur in the same cycle.
  - A store allocated in the same cycle is not visible to the lookup.
- Simultaneous events:
  - Allocate, commit, ack and lookup all update in one cycle.
  - full_o and alloc_ready_o reflect registered state, so an alloc while full is rejected even if an ack frees a slot that cycle.
- Reset mid-drain: all entries are discarded and mem_req_o deasserts next cycle.

Optional Feature:
STORE_QUEUE_BYTE_MERGE_EN.
- Defined: each byte lane independently takes the youngest matching entry whose mask bit is set. load_mask_o is the OR of the matched masks, and load_hit_o = |load_mask_o.
- Undefined: the whole youngest word-matching entry is returned with its own mask.

Decomposition:
- Shared package/header holds the entry typedef (addr, data, mask), the defaults for DEPTH/ADDR_LEN/DATA_LEN, and the byte-offset bit constant.
- One sub-module, store_queue_fwd_match: a wrap-aware youngest-first priority matcher. It takes valid/addr/mask vectors, head and tail, and returns the hit, index and per-lane selection.

Test Plan:
- Fill: 16 allocs (0x100..0x13C, data=i), no commit -> full_o=1, count_o=16, alloc_ready_o=0; 17th alloc dropped; mem_req_o=0.
- Commit 3 of 5 stores, hold mem_ack_i=0 for 4 cycles -> mem_req_o=1 with mem_addr_o stable at the first store's address. Then ack every cycle -> exactly 3 writes in order, then mem_req_o=0.
- Stores to 0x200 (data 0xAAAA_AAAA), then to 0x200 (data 0x1111_2222), then load 0x200 -> next cycle load_hit_o=1, load_data_o=0x1111_2222, load_mask_o=0xF.
- Commit 2 of 4 stores, flush_i together with alloc_valid_i -> count_o=2, alloc dropped. Load to the address of a flushed store -> load_hit_o=0. The remaining 2 entries drain normally.
- Wrap: 40 alloc/commit/ack cycles with concurrent traffic -> FIFO order is preserved across pointer wrap, and empty_o=1 at the end.
- With STORE_QUEUE_BYTE_MERGE_EN: store mask 0x3 data 0x0000_BBBB, then mask 0xC data 0xCCCC_0000 to the same word; load -> load_data_o=0xCCCC_BBBB, load_mask_o=0xF.
